// File: rtl/mmio_uart_fifo_periph.sv
// MMIO peripheral block: UART TX through a drain FIFO, UART RX pop, LEDs, buttons with latched
// rising-edge events, and a maskable level interrupt behind a valid/ready bus.
module mmio_uart_fifo_periph #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned NUM_LEDS    = 2,
  parameter int unsigned NUM_BUTTONS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mmio_valid,
  input  logic                   mmio_write,
  input  logic [31:0]            mmio_addr,
  input  logic [31:0]            mmio_wdata,
  input  logic [3:0]             mmio_wstrb,
  output logic [31:0]            mmio_rdata,
  output logic                   mmio_ready,
  output logic [7:0]             uart_tx_data,
  output logic                   uart_tx_valid,
  input  logic                   uart_tx_busy,
  input  logic [7:0]             uart_rx_data,
  output logic                   uart_rx_rd_en,
  input  logic                   uart_rx_empty,
  output logic [NUM_LEDS-1:0]    led,
  input  logic [NUM_BUTTONS-1:0] btn_sync,
  output logic                   irq
);

  localparam int unsigned AW = $clog2(TX_DEPTH);

  typedef enum logic [1:0] {StIdle, StSend, StGuard} drain_e;

  logic [7:0]             fifo_mem [TX_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  drain_e                 state;
  logic [NUM_LEDS-1:0]    led_reg;
  logic [NUM_BUTTONS-1:0] btn_prev, btn_evt, btn_rise, btn_clr;
  logic                   primed;
  logic [2:0]             irq_en, irq_pend;

  logic        fifo_empty, fifo_full, pop, push;
  logic        accept, hit, is_tx_wr, stall, ack, wr_en, rx_pop;
  logic [3:0]  sel;
  logic [8:0]  count_ext;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(TX_DEPTH));
  assign pop        = (state == StSend);
  assign accept     = mmio_valid && !mmio_ready;
  assign hit        = (mmio_addr[31:6] == BASE_ADDR[31:6]);
  assign sel        = mmio_addr[5:2];
  assign is_tx_wr   = hit && mmio_write && (sel == 4'h0);
  // A pop in this cycle frees a slot, so a full-FIFO write can be taken alongside it.
  assign stall      = is_tx_wr && fifo_full && !pop;
  assign ack        = accept && !stall;
  assign push       = ack && is_tx_wr;
  assign wr_en      = ack && hit && mmio_write;
  assign irq_pend   = {|btn_evt, ~uart_rx_empty, fifo_empty};
  assign count_ext  = 9'(count);
  assign btn_rise   = primed ? (btn_sync & ~btn_prev) : '0;
  assign btn_clr    = (wr_en && sel == 4'h7 && mmio_wstrb[0]) ? mmio_wdata[NUM_BUTTONS-1:0] : '0;
  assign unused_bits = ^{mmio_addr[1:0], mmio_wdata, mmio_wstrb[3:1], count_ext[8]};

  always_comb begin
    rd_val = '0;
    rx_pop = 1'b0;
    if (hit && !mmio_write) begin
      case (sel)
        4'h1: rd_val = {16'h0, count_ext[7:0], 5'h0, uart_tx_busy, fifo_empty, fifo_full};
        4'h2: begin
          if (!uart_rx_empty) begin
            rd_val = {24'h0, uart_rx_data};
            rx_pop = 1'b1;
          end
        end
        4'h3: rd_val = {31'h0, ~uart_rx_empty};
        4'h4: rd_val = 32'(led_reg);
        4'h6: rd_val = 32'(btn_sync);
        4'h7: rd_val = 32'(btn_evt);
        4'h8: rd_val = {29'h0, irq_en};
        4'h9: rd_val = {29'h0, irq_pend};
        default: rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mmio_ready    <= 1'b0;
      mmio_rdata    <= '0;
      uart_rx_rd_en <= 1'b0;
      led_reg       <= '0;
      led           <= '0;
      irq_en        <= '0;
      irq           <= 1'b0;
      btn_prev      <= '0;
      btn_evt       <= '0;
      primed        <= 1'b0;
    end else begin
      mmio_ready    <= ack;
      mmio_rdata    <= ack ? rd_val : '0;
      uart_rx_rd_en <= ack && rx_pop;
      if (wr_en && mmio_wstrb[0]) begin
        if (sel == 4'h4) led_reg <= mmio_wdata[NUM_LEDS-1:0];
        if (sel == 4'h8) irq_en  <= mmio_wdata[2:0];
      end
      led      <= led_reg;
      irq      <= |(irq_en & irq_pend);
      btn_prev <= btn_sync;
      primed   <= 1'b1;
      // Set after clear so a fresh edge survives a simultaneous W1C.
      btn_evt  <= (btn_evt & ~btn_clr) | btn_rise;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mmio_wdata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  // Head byte is captured on entry to StSend; the pop itself happens during StSend.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= StIdle;
      uart_tx_valid <= 1'b0;
      uart_tx_data  <= '0;
    end else begin
      uart_tx_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (!fifo_empty && !uart_tx_busy) begin
            state         <= StSend;
            uart_tx_data  <= fifo_mem[rd_ptr];
            uart_tx_valid <= 1'b1;
          end
        end
        StSend:  state <= StGuard;
        StGuard: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_fifo_periph.sv
// Directed self-checking bench for mmio_uart_fifo_periph with default parameters.
module tb_mmio_uart_fifo_periph;

  localparam logic [31:0] B = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mmio_valid, mmio_write;
  logic [31:0] mmio_addr, mmio_wdata, mmio_rdata;
  logic [3:0]  mmio_wstrb;
  logic        mmio_ready;
  logic [7:0]  uart_tx_data, uart_rx_data;
  logic        uart_tx_valid, uart_tx_busy, uart_rx_rd_en, uart_rx_empty;
  logic [1:0]  led, btn_sync;
  logic        irq;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] tx_q[$];
  int         tx_t[$];

  mmio_uart_fifo_periph dut (
    .clk(clk), .reset(reset),
    .mmio_valid(mmio_valid), .mmio_write(mmio_write), .mmio_addr(mmio_addr),
    .mmio_wdata(mmio_wdata), .mmio_wstrb(mmio_wstrb), .mmio_rdata(mmio_rdata),
    .mmio_ready(mmio_ready),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_busy(uart_tx_busy),
    .uart_rx_data(uart_rx_data), .uart_rx_rd_en(uart_rx_rd_en), .uart_rx_empty(uart_rx_empty),
    .led(led), .btn_sync(btn_sync), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (uart_tx_valid === 1'b1) begin
      tx_q.push_back(uart_tx_data);
      tx_t.push_back(cyc);
    end
  end

  // Called just after a negedge; lat is the number of negedges until mmio_ready, -1 on timeout.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int lat);
    mmio_valid = 1'b1; mmio_write = 1'b1; mmio_addr = a; mmio_wdata = d; mmio_wstrb = s;
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (mmio_ready === 1'b1) begin lat = i; break; end
    end
    mmio_valid = 1'b0; mmio_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic rden,
                          output int lat);
    mmio_valid = 1'b1; mmio_write = 1'b0; mmio_addr = a; mmio_wstrb = 4'h0;
    lat = -1; d = 'x; rden = 1'bx;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (mmio_ready === 1'b1) begin lat = i; d = mmio_rdata; rden = uart_rx_rd_en; break; end
    end
    mmio_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic r; int lat;
    n_chk++; if (led !== 2'b00) begin n_fail++; $display("FAIL reset_led got %b want 00", led); end
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
    n_chk++; if (uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_txv got %b want 0", uart_tx_valid); end
    n_chk++; if (mmio_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", mmio_ready); end
    bus_read(B + 32'h04, d, r, lat);
    n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL reset_lat got %0d want 1", lat); end
    n_chk++; if (d !== 32'h2) begin n_fail++; $display("FAIL reset_txstat got %h want 00000002", d); end
  endtask

  task automatic test_tx_order();
    int lat; logic [7:0] exp [3];
    exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
    uart_tx_busy = 1'b0;
    tx_q.delete(); tx_t.delete();
    for (int i = 0; i < 3; i++) begin
      bus_write(B, {24'h0, exp[i]}, 4'h1, lat);
      n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL txord_lat%0d got %0d want 1", i, lat); end
    end
    repeat (20) @(negedge clk);
    n_chk++; if (tx_q.size() !== 3) begin n_fail++; $display("FAIL txord_npulses got %0d want 3", tx_q.size()); end
    for (int i = 0; i < tx_q.size() && i < 3; i++) begin
      n_chk++; if (tx_q[i] !== exp[i]) begin n_fail++; $display("FAIL txord_data%0d got %h want %h", i, tx_q[i], exp[i]); end
    end
    for (int i = 1; i < tx_t.size(); i++) begin
      n_chk++; if (tx_t[i] - tx_t[i-1] < 3) begin n_fail++; $display("FAIL txord_gap%0d got %0d want >=3", i, tx_t[i] - tx_t[i-1]); end
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] d; logic r; int lat; logic early;
    uart_tx_busy = 1'b1;
    tx_q.delete(); tx_t.delete();
    for (int i = 0; i < 16; i++) begin
      bus_write(B, 32'h10 + i, 4'h1, lat);
      n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL full_lat%0d got %0d want 1", i, lat); end
    end
    bus_read(B + 32'h04, d, r, lat);
    n_chk++; if (d !== 32'h0000_1005) begin n_fail++; $display("FAIL full_stat got %h want 00001005", d); end
    mmio_valid = 1'b1; mmio_write = 1'b1; mmio_addr = B; mmio_wdata = 32'h20; mmio_wstrb = 4'h1;
    early = 1'b0;
    repeat (8) begin @(negedge clk); if (mmio_ready !== 1'b0) early = 1'b1; end
    n_chk++; if (early !== 1'b0) begin n_fail++; $display("FAIL full_stall got ack want no ack"); end
    uart_tx_busy = 1'b0;
    @(negedge clk);
    n_chk++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h10) begin n_fail++; $display("FAIL full_pop got v=%b d=%h want v=1 d=10", uart_tx_valid, uart_tx_data); end
    n_chk++; if (mmio_ready !== 1'b0) begin n_fail++; $display("FAIL full_ackearly got %b want 0", mmio_ready); end
    @(negedge clk);
    n_chk++; if (mmio_ready !== 1'b1) begin n_fail++; $display("FAIL full_ack got %b want 1", mmio_ready); end
    mmio_valid = 1'b0; mmio_write = 1'b0;
    repeat (80) @(negedge clk);
    n_chk++; if (tx_q.size() !== 17) begin n_fail++; $display("FAIL full_ndrain got %0d want 17", tx_q.size()); end
    for (int i = 0; i < tx_q.size() && i < 17; i++) begin
      n_chk++; if (tx_q[i] !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL full_data%0d got %h want %h", i, tx_q[i], 8'(8'h10 + i)); end
    end
    bus_read(B + 32'h04, d, r, lat);
    n_chk++; if (d !== 32'h2) begin n_fail++; $display("FAIL full_drained got %h want 00000002", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic r; int lat; logic acked;
    uart_tx_busy = 1'b1;
    tx_q.delete();
    for (int i = 0; i < 3; i++) bus_write(B, 32'h61 + i, 4'h1, lat);
    bus_read(B + 32'h04, d, r, lat);
    n_chk++; if (d !== 32'h0000_0304) begin n_fail++; $display("FAIL mid_stat got %h want 00000304", d); end
    mmio_valid = 1'b1; mmio_write = 1'b1; mmio_addr = B; mmio_wdata = 32'h99; mmio_wstrb = 4'h1;
    @(posedge clk); #1;
    reset = 1'b1; uart_tx_busy = 1'b0; mmio_valid = 1'b0; mmio_write = 1'b0;
    acked = 1'b0;
    repeat (2) begin @(negedge clk); if (mmio_ready !== 1'b0) acked = 1'b1; end
    reset = 1'b0;
    repeat (3) begin @(negedge clk); if (mmio_ready !== 1'b0) acked = 1'b1; end
    n_chk++; if (acked !== 1'b0) begin n_fail++; $display("FAIL mid_noack got ack want none"); end
    bus_read(B + 32'h04, d, r, lat);
    n_chk++; if (d !== 32'h2) begin n_fail++; $display("FAIL mid_count got %h want 00000002", d); end
    repeat (5) @(negedge clk);
    n_chk++; if (tx_q.size() !== 0) begin n_fail++; $display("FAIL mid_nosend got %0d want 0", tx_q.size()); end
  endtask

  task automatic test_rx();
    logic [31:0] d; logic r; int lat;
    uart_rx_empty = 1'b0; uart_rx_data = 8'h5A;
    bus_read(B + 32'h08, d, r, lat);
    n_chk++; if (d !== 32'h5A || r !== 1'b1) begin n_fail++; $display("FAIL rx_pop got d=%h en=%b want d=0000005a en=1", d, r); end
    bus_read(B + 32'h0C, d, r, lat);
    n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL rx_stat1 got %h want 00000001", d); end
    uart_rx_empty = 1'b1;
    bus_read(B + 32'h08, d, r, lat);
    n_chk++; if (d !== 32'h0 || r !== 1'b0) begin n_fail++; $display("FAIL rx_empty got d=%h en=%b want d=0 en=0", d, r); end
    bus_read(B + 32'h0C, d, r, lat);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL rx_stat0 got %h want 0", d); end
  endtask

  task automatic test_btn_irq();
    logic [31:0] d; logic r; int lat;
    bus_write(B + 32'h20, 32'h4, 4'h1, lat);
    bus_read(B + 32'h20, d, r, lat);
    n_chk++; if (d !== 32'h4) begin n_fail++; $display("FAIL btn_irqen got %h want 00000004", d); end
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL btn_irq_idle got %b want 0", irq); end
    btn_sync = 2'b10;
    repeat (2) @(negedge clk);
    n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL btn_irq_set got %b want 1", irq); end
    btn_sync = 2'b00;
    bus_read(B + 32'h1C, d, r, lat);
    n_chk++; if (d !== 32'h2) begin n_fail++; $display("FAIL btn_evt got %h want 00000002", d); end
    bus_read(B + 32'h24, d, r, lat);
    n_chk++; if (d !== 32'h5) begin n_fail++; $display("FAIL btn_pend got %h want 00000005", d); end
    bus_write(B + 32'h1C, 32'h2, 4'h1, lat);
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL btn_irq_clr got %b want 0", irq); end
    bus_read(B + 32'h1C, d, r, lat);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL btn_evt_clr got %h want 0", d); end
    btn_sync = 2'b10;
    bus_write(B + 32'h1C, 32'h2, 4'h1, lat);
    bus_read(B + 32'h1C, d, r, lat);
    n_chk++; if (d !== 32'h2) begin n_fail++; $display("FAIL btn_setwins got %h want 00000002", d); end
    n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL btn_irq_again got %b want 1", irq); end
    btn_sync = 2'b00;
    bus_write(B + 32'h1C, 32'h2, 4'h1, lat);
    bus_read(B + 32'h1C, d, r, lat);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL btn_evt_clr2 got %h want 0", d); end
  endtask

  task automatic test_led_decode();
    logic [31:0] d; logic r; int lat;
    bus_write(B + 32'h10, 32'h3, 4'h0, lat);
    repeat (2) @(negedge clk);
    n_chk++; if (led !== 2'b00) begin n_fail++; $display("FAIL led_nostrb got %b want 00", led); end
    mmio_valid = 1'b1; mmio_write = 1'b1; mmio_addr = B + 32'h10; mmio_wdata = 32'h3; mmio_wstrb = 4'h1;
    @(negedge clk);
    n_chk++; if (mmio_ready !== 1'b1 || led !== 2'b00) begin n_fail++; $display("FAIL led_early got rdy=%b led=%b want rdy=1 led=00", mmio_ready, led); end
    mmio_valid = 1'b0; mmio_write = 1'b0;
    @(negedge clk);
    n_chk++; if (led !== 2'b11) begin n_fail++; $display("FAIL led_set got %b want 11", led); end
    bus_read(B + 32'h10, d, r, lat);
    n_chk++; if (d !== 32'h3) begin n_fail++; $display("FAIL led_rd got %h want 00000003", d); end
    bus_read(B + 32'h3C, d, r, lat);
    n_chk++; if (d !== 32'h0 || lat !== 1) begin n_fail++; $display("FAIL unmapped got d=%h lat=%0d want d=0 lat=1", d, lat); end
    bus_read(32'h0000_0010, d, r, lat);
    n_chk++; if (d !== 32'h0 || lat !== 1) begin n_fail++; $display("FAIL miss_rd got d=%h lat=%0d want d=0 lat=1", d, lat); end
    bus_write(32'h0000_0010, 32'h0, 4'h1, lat);
    repeat (2) @(negedge clk);
    n_chk++; if (led !== 2'b11 || lat !== 1) begin n_fail++; $display("FAIL miss_wr got led=%b lat=%0d want led=11 lat=1", led, lat); end
    bus_read(B, d, r, lat);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL txdata_rd got %h want 0", d); end
  endtask

  initial begin
    reset = 1'b1;
    mmio_valid = 1'b0; mmio_write = 1'b0; mmio_addr = '0; mmio_wdata = '0; mmio_wstrb = '0;
    uart_tx_busy = 1'b0; uart_rx_data = '0; uart_rx_empty = 1'b1; btn_sync = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_tx_order();
    test_fifo_full();
    test_reset_mid();
    test_rx();
    test_btn_irq();
    test_led_decode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_fifo_periph.md
Name: mmio_uart_fifo_periph

Overview:
Parametrised successor to the platform's MMIO peripheral register block. It serves UART TX/RX, N LEDs and N buttons over the same valid/ready MMIO bus. New relative to the previous generation: a TX FIFO, so CPU writes no longer stall on a busy UART; latched button edge events; and a maskable level interrupt. It sits between the memory controller's MMIO port and the UART, LED and button pins.

Parameters:
BASE_ADDR, 32'h80000000, register window base; the window is 64 bytes and BASE_ADDR[5:0] must be 0.
TX_DEPTH, 16, TX FIFO entries; must be a power of 2, from 2 to 256.
NUM_LEDS, 2, LED outputs, 1..8.
NUM_BUTTONS, 2, button inputs, 1..8.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
mmio_valid  in  1  request; held high until mmio_ready
mmio_write  in  1  1=write, 0=read
mmio_addr  in  32  byte address
mmio_wdata  in  32  write data
mmio_wstrb  in  4  byte strobes
mmio_rdata  out  32  read data; valid while mmio_ready=1
mmio_ready  out  1  one-cycle acknowledge
uart_tx_data  out  8  byte to UART transmitter
uart_tx_valid  out  1  one-cycle send strobe
uart_tx_busy  in  1  transmitter busy; rises no later than the cycle after uart_tx_valid
uart_rx_data  in  8  head byte of the RX buffer
uart_rx_rd_en  out  1  one-cycle pop of the RX buffer
uart_rx_empty  in  1  RX buffer empty
led  out  NUM_LEDS  LED drive, registered
btn_sync  in  NUM_BUTTONS  pre-synchronised buttons, 1=pressed
irq  out  1  registered level interrupt

Behaviour:
- Reset (async assert, sync release) clears all outputs, all registers, the FIFO pointers and count, and the drain FSM state (→IDLE). Any in-flight transaction is dropped without ack.
- Handshake: a request is accepted when mmio_valid && !mmio_ready. mmio_ready pulses exactly 1 cycle, registered, 1 cycle after acceptance unless stalled. Accesses are never acked on back-to-back cycles.
- Decode: hit when mmio_addr[31:6]==BASE_ADDR[31:6]; register select is mmio_addr[5:2]. A miss or unmapped offset acks immediately; reads return 0 and writes are ignored.
- Register map (offset: access, content):
  0x00 TX_DATA: W pushes wdata[7:0]. If the FIFO is full, no ack; ack occurs the cycle after space frees. R returns 0.
  0x04 TX_STATUS: R returns {16'h0, count[7:0], 5'h0, uart_tx_busy, empty, full}.
  0x08 RX_DATA: R, if !uart_rx_empty, returns {24'h0, uart_rx_data} and pulses uart_rx_rd_en together with mmio_ready. If empty, returns 0 and no pop.
  0x0C RX_STATUS: R returns {31'h0, ~uart_rx_empty}.
  0x10 LED: R/W, bits[NUM_LEDS-1:0]. Writes apply only if wstrb[0]. The led output follows the register 1 cycle later.
  0x18 BTN_LEVEL: R returns btn_sync zero-extended.
  0x1C BTN_EVENT: R returns latched rising edges. W is write-1-to-clear, gated by wstrb[0].
  0x20 IRQ_EN: R/W bits[2:0]. bit0 = TX FIFO empty, bit1 = RX available, bit2 = any BTN_EVENT. Writes gated by wstrb[0].
  0x24 IRQ_PEND: R returns the unmasked raw sources {evt!=0, ~rx_empty, tx_empty}.
- TX FIFO: circular buffer; pointers are log2(TX_DEPTH) bits and wrap naturally; count is log2(TX_DEPTH)+1 bits. A push and a pop in the same cycle leave count unchanged; a push while full is impossible because of the stall.
- Drain FSM:
  IDLE: if FIFO not empty and !uart_tx_busy → SEND.
  SEND: drive the head byte on uart_tx_data, uart_tx_valid=1 for 1 cycle, pop → GUARD.
  GUARD: one-cycle hold covering busy latency → IDLE.
  Minimum spacing between uart_tx_valid pulses is 3 cycles. uart_tx_data holds its value between sends.
- Button events: btn_prev resets to 0. A primed flag suppresses edge latching in the first cycle after reset release. Each event bit sets on btn_sync & ~btn_prev. If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- irq is registered and equals |(IRQ_EN & IRQ_PEND); it is 1-cycle delayed from its sources.
- Read data always reflects register state from before any write in the same cycle.

Test Plan:
- Reset, then read 0x04 → 0x00000002 (FIFO empty). Check led=0, irq=0, uart_tx_valid=0; also assert reset mid-transfer and confirm the count returns to 0 with no ack.
- With uart_tx_busy=0, write 0x41,0x42,0x43 to 0x00 → three uart_tx_valid pulses carrying 0x41,0x42,0x43 in order, at least 3 cycles apart.
- Hold uart_tx_busy=1 and write 17 bytes with TX_DEPTH=16 → first 16 acked and count=16. The 17th stalls, then acks 1 cycle after busy drops and the first pop occurs.
- uart_rx_empty=0, uart_rx_data=0x5A, read 0x08 → rdata=0x5A with rd_en and ready in the same cycle. With uart_rx_empty=1 → rdata=0 and no rd_en.
- IRQ_EN=4, pulse btn_sync[1] → BTN_EVENT=0x2 and irq=1. Write 0x2 to 0x1C → irq=0. A new edge landing in the clear cycle must stay set.
- Write 0x3 to 0x10 with wstrb=0 → led unchanged. With wstrb=1 → led=2'b11 one cycle later; an unmapped offset 0x3C read → 0 with ack.
